// File: rtl/carry_sched.sv
// Round-robin scheduler sharing one 4-bit carry slice between two requesters.
// Each operation walks the operand nibble by nibble, chaining the slice carry.
module carry_sched #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           req_valid,
  output logic [1:0]           req_ready,
  input  logic [4*NIBBLES-1:0] req_data0,
  input  logic [4*NIBBLES-1:0] req_data1,
  input  logic [1:0]           req_cin,
  output logic [3:0]           slice_i,
  output logic                 slice_cin,
  input  logic                 slice_o,
  input  logic                 slice_cout,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_id,
  output logic [NIBBLES-1:0]   rsp_result,
  output logic                 rsp_cout
);

  localparam int W  = 4 * NIBBLES;
  localparam int SW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [SW-1:0] LAST = SW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state_q, state_d;
  logic              ptr_q, ptr_d;
  logic [SW-1:0]     step_q, step_d;
  logic              carry_q, carry_d;
  logic [W-1:0]      op_q, op_d;
  logic              cin_q, cin_d;
  logic              id_q, id_d;
  logic [NIBBLES-1:0] res_q, res_d;
  logic              cout_q, cout_d;
  logic              gnt;
  logic [W-1:0]      op_sh;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    step_d    = step_q;
    carry_d   = carry_q;
    op_d      = op_q;
    cin_d     = cin_q;
    id_d      = id_q;
    res_d     = res_q;
    cout_d    = cout_q;
    req_ready = '0;
    slice_i   = '0;
    slice_cin = 1'b0;
    gnt       = req_valid[ptr_q] ? ptr_q : ~ptr_q;
    op_sh     = op_q >> (4 * step_q);
    unique case (state_q)
      IDLE: begin
        if (|req_valid && !rst) begin
          req_ready[gnt] = 1'b1;
          op_d    = gnt ? req_data1 : req_data0;
          cin_d   = req_cin[gnt];
          id_d    = gnt;
          step_d  = '0;
          res_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        slice_i   = op_sh[3:0];
        slice_cin = (step_q == '0) ? cin_q : carry_q;
        res_d[step_q] = slice_o;
        carry_d   = slice_cout;
        if (step_q == LAST) begin
          state_d = DONE;
          cout_d  = slice_cout;
        end else begin
          step_d = step_q + 1'b1;
        end
      end
      DONE: begin
        // hand priority to the other requester once this one is served
        if (rsp_ready) begin
          state_d = IDLE;
          ptr_d   = ~id_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      step_q  <= '0;
      carry_q <= 1'b0;
      op_q    <= '0;
      cin_q   <= 1'b0;
      id_q    <= 1'b0;
      res_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      step_q  <= step_d;
      carry_q <= carry_d;
      op_q    <= op_d;
      cin_q   <= cin_d;
      id_q    <= id_d;
      res_q   <= res_d;
      cout_q  <= cout_d;
    end
  end

  assign rsp_valid  = (state_q == DONE);
  assign rsp_id     = id_q;
  assign rsp_result = res_q;
  assign rsp_cout   = cout_q;

endmodule

// File: tb/tb_carry_sched.sv
// Scoreboard bench for carry_sched with a behavioural slice model.
// Grants push expected responses; a monitor checks them as they appear.
module tb_carry_sched;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [15:0] req_data0;
  logic [15:0] req_data1;
  logic [1:0]  req_cin;
  logic [3:0]  slice_i;
  logic        slice_cin;
  logic        slice_o;
  logic        slice_cout;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [3:0]  rsp_result;
  logic        rsp_cout;

  carry_sched #(.NIBBLES(N)) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_data0(req_data0),
    .req_data1(req_data1),
    .req_cin(req_cin),
    .slice_i(slice_i),
    .slice_cin(slice_cin),
    .slice_o(slice_o),
    .slice_cout(slice_cout),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_id(rsp_id),
    .rsp_result(rsp_result),
    .rsp_cout(rsp_cout)
  );

  assign slice_o    = (^slice_i) ^ slice_cin;
  assign slice_cout = (&slice_i) | (slice_cin & (|slice_i));

  always #5 clk = ~clk;

  typedef struct {
    logic       id;
    logic [3:0] res;
    logic       cout;
    int         acc;
  } exp_t;

  exp_t sb[$];
  int   grants[$];
  int   gcyc[$];
  int   chk = 0;
  int   err = 0;
  int   cyc = 0;
  logic [3:0] exp_res [2];
  logic       exp_cout [2];
  logic       prev_v = 1'b0;
  exp_t       w_e;
  exp_t       m_e;

  always @(posedge clk) cyc <= cyc + 1;

  // accept watcher: one-hot grant check and scoreboard push
  always @(negedge clk) begin
    chk++;
    if ($countones(req_ready) > 1 || (req_ready & ~req_valid) != 2'b00) begin
      err++;
      $display("FAIL grant_onehot cyc=%0d ready=%b valid=%b", cyc, req_ready, req_valid);
    end
    if (!rst) begin
      for (int g = 0; g < 2; g++) begin
        if (req_valid[g] && req_ready[g]) begin
          w_e.id   = 1'(g);
          w_e.res  = exp_res[g];
          w_e.cout = exp_cout[g];
          w_e.acc  = cyc;
          sb.push_back(w_e);
          grants.push_back(g);
          gcyc.push_back(cyc);
        end
      end
    end
  end

  // response monitor
  always @(negedge clk) begin
    if (rsp_valid) begin
      if (sb.size() == 0) begin
        chk++;
        err++;
        $display("FAIL unexpected_rsp id=%0d res=%h", rsp_id, rsp_result);
      end else begin
        m_e = sb[0];
        if (!prev_v) begin
          chk++;
          if (cyc - m_e.acc != N + 1) begin
            err++;
            $display("FAIL latency got=%0d want=%0d", cyc - m_e.acc, N + 1);
          end
        end
        chk++;
        if (rsp_id !== m_e.id || rsp_result !== m_e.res || rsp_cout !== m_e.cout ||
            req_ready !== 2'b00 || slice_i !== 4'h0 || slice_cin !== 1'b0) begin
          err++;
          $display("FAIL rsp got id=%0d res=%h cout=%b rdy=%b si=%h sc=%b want id=%0d res=%h cout=%b rdy=0 si=0 sc=0",
                   rsp_id, rsp_result, rsp_cout, req_ready, slice_i, slice_cin,
                   m_e.id, m_e.res, m_e.cout);
        end
        if (rsp_ready) void'(sb.pop_front());
      end
    end
    prev_v = rsp_valid;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int g);
    req_valid[g] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready[g]) break;
    end
    if (!req_ready[g]) begin
      chk++;
      err++;
      $display("FAIL issue_timeout req=%0d ready=%b want grant", g, req_ready);
    end
    tick();
    req_valid[g] = 1'b0;
  endtask

  task automatic check_slices(input logic [15:0] nis, input logic [3:0] cins);
    for (int k = 0; k < N; k++) begin
      @(negedge clk);
      chk++;
      if (slice_i !== nis[4*k +: 4] || slice_cin !== cins[k]) begin
        err++;
        $display("FAIL slice step=%0d got i=%h cin=%b want i=%h cin=%b",
                 k, slice_i, slice_cin, nis[4*k +: 4], cins[k]);
      end
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 60; i++) begin
      if (sb.size() == 0) break;
      tick();
    end
    chk++;
    if (sb.size() != 0) begin
      err++;
      $display("FAIL drain_timeout pending=%0d want 0", sb.size());
    end
  endtask

  task automatic check_zero(input string nm);
    @(negedge clk);
    chk++;
    if ({rsp_valid, req_ready, slice_i, slice_cin, rsp_id, rsp_result, rsp_cout} !== '0) begin
      err++;
      $display("FAIL %s got v=%b rdy=%b si=%h sc=%b id=%b res=%h cout=%b want all 0",
               nm, rsp_valid, req_ready, slice_i, slice_cin, rsp_id, rsp_result, rsp_cout);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst         = 1'b1;
    req_valid   = 2'b00;
    rsp_ready   = 1'b1;
    req_data0   = 16'hF0A1;
    req_data1   = 16'h0001;
    req_cin     = 2'b10;
    exp_res[0]  = 4'h1;
    exp_cout[0] = 1'b1;
    exp_res[1]  = 4'h2;
    exp_cout[1] = 1'b0;
    repeat (2) tick();
    check_zero("reset_state");
    tick();
    rst = 1'b0;

    // single op from requester 0, inputs disturbed mid-run
    issue(0);
    req_data0    = 16'h1234;
    req_valid[1] = 1'b1;
    check_slices(16'hF0A1, 4'b0000);
    #1;
    req_valid[1] = 1'b0;
    req_data0    = 16'hF0A1;
    drain();

    // single op from requester 1 with carry-in
    issue(1);
    check_slices(16'h0001, 4'b0011);
    drain();

    // both requesters continuously valid
    grants.delete();
    gcyc.delete();
    req_valid = 2'b11;
    for (int i = 0; i < 100; i++) begin
      if (grants.size() >= 4) break;
      tick();
    end
    req_valid = 2'b00;
    chk++;
    if (grants.size() != 4) begin
      err++;
      $display("FAIL grant_count got=%0d want=4", grants.size());
    end
    for (int i = 0; i < 4 && i < grants.size(); i++) begin
      chk++;
      if (grants[i] != i % 2) begin
        err++;
        $display("FAIL grant_order idx=%0d got=%0d want=%0d", i, grants[i], i % 2);
      end
    end
    for (int i = 1; i < 4 && i < gcyc.size(); i++) begin
      chk++;
      if (gcyc[i] - gcyc[i-1] != N + 2) begin
        err++;
        $display("FAIL grant_period idx=%0d got=%0d want=%0d", i, gcyc[i] - gcyc[i-1], N + 2);
      end
    end
    drain();

    // consumer stall in DONE with both requesters waiting
    rsp_ready = 1'b0;
    issue(0);
    req_valid = 2'b11;
    for (int i = 0; i < 20; i++) begin
      if (rsp_valid) break;
      tick();
    end
    repeat (10) tick();
    rsp_ready = 1'b1;
    req_valid = 2'b00;
    tick();
    @(negedge clk);
    chk++;
    if (rsp_valid !== 1'b0 || sb.size() != 0) begin
      err++;
      $display("FAIL stall_release got v=%b pending=%0d want v=0 pending=0", rsp_valid, sb.size());
    end
    drain();

    // reset in the middle of a run
    issue(1);
    tick();
    tick();
    rst       = 1'b1;
    req_valid = 2'b11;
    @(negedge clk);
    chk++;
    if (req_ready !== 2'b00 || rsp_valid !== 1'b0) begin
      err++;
      $display("FAIL reset_cycle got rdy=%b v=%b want 00 0", req_ready, rsp_valid);
    end
    tick();
    rst       = 1'b0;
    req_valid = 2'b00;
    sb.delete();
    check_zero("post_reset");
    tick();
    req_valid = 2'b11;
    @(negedge clk);
    chk++;
    if (req_ready !== 2'b01) begin
      err++;
      $display("FAIL post_reset_ptr got=%b want=01", req_ready);
    end
    tick();
    req_valid = 2'b00;
    drain();

    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", err, chk);
    $finish;
  end

endmodule

// File: doc/carry_sched.md
CARRY_SCHED -- requirements
Module: carry_sched

Interface
- REQ-001: The module SHALL have one parameter: NIBBLES, default 4, the number of 4-bit carry-slice steps per operation (operand width 4*NIBBLES).
- REQ-002: The module SHALL have the following ports, one per line: name, direction, width, meaning.
  - clk  in  1  single clock; all state changes on the rising edge.
  - rst  in  1  synchronous, active-high reset.
  - req_valid  in  2  requester r has an operation pending.
  - req_ready  out  2  the grant/accept strobe for requester r.
  - req_data0  in  4*NIBBLES  operand of requester 0.
  - req_data1  in  4*NIBBLES  operand of requester 1.
  - req_cin  in  2  carry-in of requester r.
  - slice_i  out  4  nibble driven to the shared carry slice.
  - slice_cin  out  1  carry-in driven to the shared carry slice.
  - slice_o  in  1  combinational result bit from the slice.
  - slice_cout  in  1  combinational carry-out from the slice.
  - rsp_valid  out  1  a response is available.
  - rsp_ready  in  1  the consumer accepts the response.
  - rsp_id  out  1  requester that owns the response.
  - rsp_result  out  NIBBLES  collected slice_o bits; bit k is from step k.
  - rsp_cout  out  1  slice_cout of the final step.

Function
- REQ-003: The module SHALL implement the FSM states IDLE, RUN and DONE.
- REQ-004: In IDLE with any req_valid set, the module SHALL assert req_ready for exactly one requester: the one pointed to by the round-robin pointer if it is valid, otherwise the other one.
- REQ-005: req_ready SHALL be 0 in RUN and DONE, and 0 in IDLE when no req_valid bit is set.
- REQ-006: On req_valid[g] & req_ready[g], the module SHALL latch operand g, req_cin[g] and id g, clear step and result, and move to RUN.
- REQ-007: In RUN, the module SHALL drive slice_i = operand[4*step+3 : 4*step], with nibbles taken LSB first.
- REQ-008: In RUN, slice_cin SHALL equal the latched cin at step 0 and the registered carry at every later step.
- REQ-009: Each RUN cycle, the module SHALL register result[step] <= slice_o and carry <= slice_cout, then increment step.
- REQ-010: When step = NIBBLES-1, the module SHALL move to DONE instead of incrementing, with rsp_cout <= slice_cout.
- REQ-011: Outside RUN, slice_i and slice_cin SHALL be 0.
- REQ-012: Latency: a request accepted in cycle T SHALL give rsp_valid = 1 in cycle T+NIBBLES+1.
- REQ-013: In DONE, rsp_valid SHALL be 1, and rsp_id, rsp_result and rsp_cout SHALL hold stable until rsp_ready = 1.
- REQ-014: On rsp_valid & rsp_ready, the module SHALL return to IDLE and set the pointer to the requester not just served.
- REQ-015: The module SHALL accept no new request in the cycle a response is consumed; the minimum period between operations is NIBBLES+2 cycles.
- REQ-016: If req_valid drops before the grant, no transaction SHALL occur. req_valid changes during RUN or DONE SHALL have no effect.
- REQ-017: When both requesters are continuously valid, grants SHALL alternate 0,1,0,1,...

Reset
- REQ-018: While rst = 1 at a clock edge, the module SHALL set: state IDLE, pointer 0, step 0, carry 0, rsp_valid 0, rsp_result 0, rsp_cout 0, rsp_id 0.
- REQ-019: Reset asserted in RUN or DONE SHALL abandon the operation with no response. req_ready SHALL be 0 during the reset cycle.

Verification (bench slice model: slice_o = XOR of slice_i bits and slice_cin; slice_cout = &slice_i | (slice_cin & |slice_i); NIBBLES = 4)
- REQ-020: Requester 0 sends data 0xF0A1 with cin 0 -> slice_i sequence 1,A,0,F; rsp_result = 0x1, rsp_cout = 1, rsp_id = 0, rsp_valid 5 cycles after accept.
- REQ-021: Requester 1 sends data 0x0001 with cin 1 -> slice_cin sequence 1,1,0,0; rsp_result = 0x2, rsp_cout = 0, rsp_id = 1.
- REQ-022: Both requesters valid from reset for 4 operations -> grant order 0,1,0,1, and req_ready is one-hot or 0 in every cycle.
- REQ-023: rsp_ready held 0 for 10 cycles in DONE -> outputs stable, req_ready stays 0, no slice activity; the response completes on the first cycle rsp_ready = 1.
- REQ-024: rst pulsed at step 2 of RUN -> next cycle in IDLE with all outputs 0, no rsp_valid, and a following request completes normally with pointer priority 0.
